// File: rtl/hci_package.sv
// Shared types for the HCI n-way arbiter: the arbitration-mode encoding.
package hci_package;

    typedef enum logic {
        HCI_ARB_FIXED = 1'b0,  // lowest requesting index wins
        HCI_ARB_RR    = 1'b1   // rotate priority after each grant
    } hci_arb_mode_t;

endpackage

// File: rtl/hci_nway_arbiter_if.sv
// Bundle of the initiator-side and bank-side signals of hci_nway_arbiter so
// an environment can carry them as one object. "master" is the side that
// drives requests and bank responses; "slave" is the arbiter's view.
interface hci_nway_arbiter_if #(
    parameter int N_IN = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    localparam int BW = DW / 8;

    // Initiator channels
    logic [N_IN-1:0]         in_req;
    logic [N_IN-1:0][AW-1:0] in_add;
    logic [N_IN-1:0]         in_wen;
    logic [N_IN-1:0][BW-1:0] in_be;
    logic [N_IN-1:0][DW-1:0] in_data;
    logic [N_IN-1:0]         in_gnt;
    logic [N_IN-1:0]         in_r_valid;
    logic [DW-1:0]           in_r_data;

    // Bank side
    logic                    mem_req;
    logic [AW-1:0]           mem_add;
    logic                    mem_wen;
    logic [BW-1:0]           mem_be;
    logic [DW-1:0]           mem_data;
    logic                    mem_gnt;
    logic [DW-1:0]           mem_r_data;

    modport master (
        output in_req, in_add, in_wen, in_be, in_data, mem_gnt, mem_r_data,
        input  in_gnt, in_r_valid, in_r_data,
               mem_req, mem_add, mem_wen, mem_be, mem_data
    );

    modport slave (
        input  in_req, in_add, in_wen, in_be, in_data, mem_gnt, mem_r_data,
        output in_gnt, in_r_valid, in_r_data,
               mem_req, mem_add, mem_wen, mem_be, mem_data
    );

endinterface

// File: rtl/hci_stall_counter.sv
// Per-channel stall counter: counts cycles a channel waits with its request
// up and no grant, saturates at all-ones, and flags starvation once the
// count reaches the channel's threshold (threshold 0 = never starve).
module hci_stall_counter #(
    parameter int SW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          gnt_i,
    input  logic [SW-1:0] max_stall_i,
    output logic          starve_o
);
    localparam logic [SW-1:0] CNT_MAX = '1;

    logic [SW-1:0] count_q;

    // Wait counter: clear on grant or idle, otherwise count up and hold at max.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the clock edge.
        if (rst_i) begin
            count_q <= '0;
        end else if (!req_i || gnt_i) begin
            count_q <= '0;
        end else if (count_q != CNT_MAX) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign starve_o = (max_stall_i != '0) && (count_q >= max_stall_i);

endmodule

// File: rtl/hci_nway_arbiter.sv
// N-way arbiter in front of a single memory bank. One winner per cycle is
// picked combinationally (starving channels first, then fixed priority or
// round-robin), forwarded to the bank and granted with zero latency when the
// bank accepts. The response valid follows each grant by exactly one cycle.
module hci_nway_arbiter
    import hci_package::*;
#(
    parameter int N_IN = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int SW   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mode_i,
    input  logic [N_IN-1:0][SW-1:0] max_stall_i,

    input  logic [N_IN-1:0]         in_req_i,
    input  logic [N_IN-1:0][AW-1:0] in_add_i,
    input  logic [N_IN-1:0]         in_wen_i,
    input  logic [N_IN-1:0][DW/8-1:0] in_be_i,
    input  logic [N_IN-1:0][DW-1:0] in_data_i,
    output logic [N_IN-1:0]         in_gnt_o,
    output logic [N_IN-1:0]         in_r_valid_o,
    output logic [DW-1:0]           in_r_data_o,

    output logic                    mem_req_o,
    output logic [AW-1:0]           mem_add_o,
    output logic                    mem_wen_o,
    output logic [DW/8-1:0]         mem_be_o,
    output logic [DW-1:0]           mem_data_o,
    input  logic                    mem_gnt_i,
    input  logic [DW-1:0]           mem_r_data_i,

    output logic [N_IN-1:0]         starve_o
);
    localparam int PW = $clog2(N_IN);

    hci_arb_mode_t   mode;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   winner;
    logic            win_valid;
    logic            grant_any;
    logic [N_IN-1:0] starve_req;
    logic [N_IN-1:0] r_valid_q;

    assign mode       = hci_arb_mode_t'(mode_i);
    assign starve_req = starve_o & in_req_i;
    assign win_valid  = |in_req_i;
    assign mem_req_o  = win_valid;
    assign grant_any  = win_valid & mem_gnt_i;

    // One stall counter per channel; its starve flag feeds the winner select.
    for (genvar k = 0; k < N_IN; k++) begin : g_stall
        hci_stall_counter #(
            .SW (SW)
        ) u_stall (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .req_i       (in_req_i[k]),
            .gnt_i       (in_gnt_o[k]),
            .max_stall_i (max_stall_i[k]),
            .starve_o    (starve_o[k])
        );
    end

    // Winner select: starving requesters first, then fixed or round-robin.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        winner = '0;
        if (|starve_req) begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                if (starve_req[k]) winner = PW'(k);
            end
        end else if (mode == HCI_ARB_FIXED) begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                if (in_req_i[k]) winner = PW'(k);
            end
        end else begin
            // Descending offset so the candidate closest to rr_ptr wins last.
            for (int o = N_IN - 1; o >= 0; o--) begin
                if (in_req_i[PW'((int'(rr_ptr_q) + o) % N_IN)]) begin
                    winner = PW'((int'(rr_ptr_q) + o) % N_IN);
                end
            end
        end
    end

    // Forward the winner's request to the bank and raise its grant bit.
    always_comb begin
        mem_add_o  = '0;
        mem_wen_o  = 1'b0;
        mem_be_o   = '0;
        mem_data_o = '0;
        in_gnt_o   = '0;
        if (win_valid) begin
            mem_add_o  = in_add_i[winner];
            mem_wen_o  = in_wen_i[winner];
            mem_be_o   = in_be_i[winner];
            mem_data_o = in_data_i[winner];
            in_gnt_o[winner] = mem_gnt_i;
        end
    end

    // Round-robin pointer: moves past the granted channel in RR mode only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (mode == HCI_ARB_RR && grant_any) begin
            if (winner == PW'(N_IN - 1)) rr_ptr_q <= '0;
            else                         rr_ptr_q <= winner + 1'b1;
        end
    end

    // Response valid: one-cycle echo of the grant vector.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_valid_q <= '0;
        else       r_valid_q <= in_gnt_o;
    end

    // A response still in flight when reset hits is dropped, not delivered.
    assign in_r_valid_o = rst_i ? '0 : r_valid_q;
    assign in_r_data_o  = mem_r_data_i;

endmodule

// File: tb/tb_hci_nway_arbiter.sv
// Self-checking bench for hci_nway_arbiter (4 channels, 2-bit stall counters).
// Directed tables and sequences cover the named corner cases; a randomized
// phase is checked cycle by cycle against a behavioural model.
module tb_hci_nway_arbiter;
    import hci_package::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int BW = DW / 8;
    localparam int SAT = (1 << SW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [N-1:0][SW-1:0] max_stall;
    logic [N-1:0]         starve;

    hci_nway_arbiter_if #(.N_IN(N), .AW(AW), .DW(DW)) bus ();

    hci_nway_arbiter #(.N_IN(N), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mode_i       (mode),
        .max_stall_i  (max_stall),
        .in_req_i     (bus.in_req),
        .in_add_i     (bus.in_add),
        .in_wen_i     (bus.in_wen),
        .in_be_i      (bus.in_be),
        .in_data_i    (bus.in_data),
        .in_gnt_o     (bus.in_gnt),
        .in_r_valid_o (bus.in_r_valid),
        .in_r_data_o  (bus.in_r_data),
        .mem_req_o    (bus.mem_req),
        .mem_add_o    (bus.mem_add),
        .mem_wen_o    (bus.mem_wen),
        .mem_be_o     (bus.mem_be),
        .mem_data_o   (bus.mem_data),
        .mem_gnt_i    (bus.mem_gnt),
        .mem_r_data_i (bus.mem_r_data),
        .starve_o     (starve)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit model_on = 1'b0;

    // Reference model state: wait counts, next RR start, last cycle's grants.
    int           wait_cnt[N];
    int           rr_next = 0;
    logic [N-1:0] last_gnt = '0;

    // Model outputs for the current cycle
    int           exp_w;
    logic [N-1:0] exp_gnt, exp_rv, exp_st;

    typedef struct {
        logic         mode;
        logic         mg;
        logic [N-1:0] req;
        logic [N*SW-1:0] mx;
        logic [N-1:0] gnt;
        logic [N-1:0] rv;
        logic [N-1:0] st;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Evaluate what the arbiter should show this cycle from the rules.
    task automatic model_eval();
        int thr;
        exp_w = -1;
        for (int k = 0; k < N; k++) begin
            thr = int'(max_stall[k]);
            exp_st[k] = (thr != 0) && (wait_cnt[k] >= thr);
        end
        for (int k = 0; k < N; k++)
            if (exp_w < 0 && bus.in_req[k] && exp_st[k]) exp_w = k;
        if (exp_w < 0) begin
            if (mode == 1'b0) begin
                for (int k = 0; k < N; k++)
                    if (exp_w < 0 && bus.in_req[k]) exp_w = k;
            end else begin
                for (int o = 0; o < N; o++)
                    if (exp_w < 0 && bus.in_req[(rr_next + o) % N]) exp_w = (rr_next + o) % N;
            end
        end
        exp_gnt = '0;
        if (exp_w >= 0 && bus.mem_gnt) exp_gnt[exp_w] = 1'b1;
        exp_rv = rst ? '0 : last_gnt;
    endtask

    // Advance the model across the clock edge.
    task automatic model_update();
        if (rst) begin
            for (int k = 0; k < N; k++) wait_cnt[k] = 0;
            rr_next  = 0;
            last_gnt = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!bus.in_req[k] || exp_gnt[k]) wait_cnt[k] = 0;
                else if (wait_cnt[k] < SAT)       wait_cnt[k] = wait_cnt[k] + 1;
            end
            if (mode == 1'b1 && exp_gnt != '0) rr_next = (exp_w + 1) % N;
            last_gnt = exp_gnt;
        end
    endtask

    // Drive one cycle between falling and rising edge, compare against model.
    task automatic run_cycle(input logic r, input logic m, input logic g,
                             input logic [N-1:0] req, input logic [N*SW-1:0] mx);
        logic [AW-1:0] ea;
        logic          ew;
        logic [BW-1:0] eb;
        logic [DW-1:0] ed;
        @(negedge clk);
        rst          = r;
        mode         = m;
        bus.mem_gnt  = g;
        bus.in_req   = req;
        max_stall    = mx;
        for (int k = 0; k < N; k++) begin
            bus.in_add[k]  = AW'($urandom);
            bus.in_wen[k]  = 1'($urandom);
            bus.in_be[k]   = BW'($urandom);
            bus.in_data[k] = DW'($urandom);
        end
        bus.mem_r_data = DW'($urandom);
        #1;
        model_eval();
        ea = '0; ew = 1'b0; eb = '0; ed = '0;
        if (exp_w >= 0) begin
            ea = bus.in_add[exp_w];
            ew = bus.in_wen[exp_w];
            eb = bus.in_be[exp_w];
            ed = bus.in_data[exp_w];
        end
        if (model_on) begin
            check("gnt",      64'(bus.in_gnt),     64'(exp_gnt));
            check("r_valid",  64'(bus.in_r_valid), 64'(exp_rv));
            check("starve",   64'(starve),         64'(exp_st));
            check("mem_req",  64'(bus.mem_req),    64'(|req));
            check("mem_add",  64'(bus.mem_add),    64'(ea));
            check("mem_wen",  64'(bus.mem_wen),    64'(ew));
            check("mem_be",   64'(bus.mem_be),     64'(eb));
            check("mem_data", 64'(bus.mem_data),   64'(ed));
            check("r_data",   64'(bus.in_r_data),  64'(bus.mem_r_data));
        end
        model_update();
    endtask

    task automatic check_vec(input string name, input logic [N-1:0] gnt,
                             input logic [N-1:0] rv, input logic [N-1:0] st);
        check({name, ".gnt"},    64'(bus.in_gnt),     64'(gnt));
        check({name, ".r_valid"}, 64'(bus.in_r_valid), 64'(rv));
        check({name, ".starve"},  64'(starve),         64'(st));
    endtask

    initial begin
        //             mode  mg    req      mx     gnt      rv       starve
        // Fixed priority, 1010 held, channel 3 threshold 3
        tbl[0]  = '{1'b0, 1'b1, 4'b1010, 8'hC0, 4'b0010, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 4'b1010, 8'hC0, 4'b0010, 4'b0010, 4'b0000};
        tbl[2]  = '{1'b0, 1'b1, 4'b1010, 8'hC0, 4'b0010, 4'b0010, 4'b0000};
        tbl[3]  = '{1'b0, 1'b1, 4'b1010, 8'hC0, 4'b1000, 4'b0010, 4'b1000};
        tbl[4]  = '{1'b0, 1'b1, 4'b1010, 8'hC0, 4'b0010, 4'b1000, 4'b0000};
        tbl[5]  = '{1'b0, 1'b1, 4'b1010, 8'hC0, 4'b0010, 4'b0010, 4'b0000};
        tbl[6]  = '{1'b0, 1'b1, 4'b0000, 8'hC0, 4'b0000, 4'b0010, 4'b0000};
        // Bank backpressure: channel 2 waits 5 cycles, counter saturates at 3
        tbl[7]  = '{1'b0, 1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b0, 1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b0, 1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{1'b0, 1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 4'b0100};
        tbl[11] = '{1'b0, 1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 4'b0100};
        tbl[12] = '{1'b0, 1'b1, 4'b0100, 8'h30, 4'b0100, 4'b0000, 4'b0100};
        tbl[13] = '{1'b0, 1'b1, 4'b0000, 8'h30, 4'b0000, 4'b0100, 4'b0000};

        rst = 1'b1; mode = 1'b0; max_stall = '0;
        bus.mem_gnt = 1'b0; bus.in_req = '0; bus.in_add = '0; bus.in_wen = '0;
        bus.in_be = '0; bus.in_data = '0; bus.mem_r_data = '0;

        // Initial reset; outputs are checked once registers have settled.
        run_cycle(1'b1, 1'b0, 1'b1, 4'b0000, '0);
        run_cycle(1'b1, 1'b0, 1'b1, 4'b0000, '0);
        model_on = 1'b1;
        run_cycle(1'b1, 1'b0, 1'b1, 4'b0000, '0);
        check_vec("reset", 4'b0000, 4'b0000, 4'b0000);

        // Table-driven fixed-priority / starvation / backpressure vectors
        for (int i = 0; i < 14; i++) begin
            run_cycle(1'b0, tbl[i].mode, tbl[i].mg, tbl[i].req, tbl[i].mx);
            check_vec($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].rv, tbl[i].st);
        end

        // Round-robin with all four requesting: 0,1,2,3,0,... and wrap
        run_cycle(1'b1, 1'b1, 1'b1, 4'b0000, '0);
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 1'b1, 1'b1, 4'b1111, '0);
            check_vec($sformatf("rr%0d", i), 4'(1 << (i % 4)),
                      (i == 0) ? 4'b0000 : 4'(1 << ((i - 1) % 4)), 4'b0000);
        end

        // Reset the cycle after a grant: response dropped, RR restarts at 0
        run_cycle(1'b0, 1'b1, 1'b1, 4'b1111, '0);
        check_vec("mid_rst.pre", 4'b0001, 4'b1000, 4'b0000);
        run_cycle(1'b1, 1'b1, 1'b1, 4'b0000, '0);
        check_vec("mid_rst.rst", 4'b0000, 4'b0000, 4'b0000);
        run_cycle(1'b0, 1'b1, 1'b1, 4'b1111, '0);
        check_vec("mid_rst.post0", 4'b0001, 4'b0000, 4'b0000);
        run_cycle(1'b0, 1'b1, 1'b1, 4'b1111, '0);
        check_vec("mid_rst.post1", 4'b0010, 4'b0001, 4'b0000);

        // Randomized traffic against the model
        begin
            logic          m = 1'b1;
            logic [N*SW-1:0] mx = '0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 15) == 0) m = ~m;
                if ($urandom_range(0, 31) == 0) mx = (N*SW)'($urandom);
                run_cycle(($urandom_range(0, 63) == 0), m,
                          ($urandom_range(0, 3) != 0),
                          N'($urandom_range(0, 15)), mx);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
